// File: rtl/sdio_master_pkg.sv
// Shared definitions for the 3-wire SDIO master: FSM encoding, turnaround
// length and command-word layout, used by both the RTL and its bench.
package sdio_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_TURN  = 3'd3,
    ST_DATA  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Turnaround length in bit times (sclk held low, pad released).
  localparam int TURN_BITS = 1;

  // Command word is {rnw, addr}: rnw travels first on the wire.
  localparam bit CMD_RNW_FIRST = 1'b1;

endpackage

// File: rtl/sdio_tick.sv
// Half-period timebase: down-counter that strobes on the last cycle of each
// sclk half-period, qualified into a sample strobe and a bit-end strobe.
module sdio_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic phase_i,
  output logic half_o,
  output logic sample_o,
  output logic bit_o
);

  logic [7:0] cnt_q, cnt_d;

  assign half_o   = en_i && (cnt_q == 8'd0);
  assign sample_o = half_o && !phase_i;
  assign bit_o    = half_o && phase_i;

  // Held at reload while disabled so every phase starts on a fresh half.
  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (!en_i || half_o) begin
      cnt_d = 8'(CLK_DIV - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'(CLK_DIV - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdio_master.sv
// 3-wire SDIO master: shifts {rnw, addr} then writes or reads one data word
// over a single bidirectional pad driven through an IOBUF (T/I/O).
module sdio_master
  import sdio_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ABITS   = 7,
  parameter int DBITS   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             rnw_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [DBITS-1:0] wdat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DBITS-1:0] rdat_o,
  output logic             sclk_o,
  output logic             csn_o,
  output logic             sdt_o,
  output logic             sdo_o,
  input  logic             sdi_i
);

  localparam int CW = ABITS + 1;
  localparam int SW = CW + DBITS;

  state_e           state_q, state_d;
  logic [SW-1:0]    sh_q, sh_d;
  logic [DBITS-1:0] rx_q, rx_d, rdat_q, rdat_d;
  logic [15:0]      bit_q, bit_d;
  logic             rnw_q, rnw_d, hi_q, hi_d, done_q, done_d;
  logic             half, sample, bit_end;

  sdio_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (state_q != ST_IDLE),
    .phase_i (hi_q),
    .half_o  (half),
    .sample_o(sample),
    .bit_o   (bit_end)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdat_d  = rdat_q;
    bit_d   = bit_q;
    rnw_d   = rnw_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rnw_d   = rnw_i;
          sh_d    = CMD_RNW_FIRST ? {rnw_i, addr_i, wdat_i} : {addr_i, rnw_i, wdat_i};
          rx_d    = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (half) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (half) hi_d = ~hi_q;
        if (bit_end) begin
          sh_d  = {sh_q[SW-2:0], 1'b0};
          bit_d = bit_q + 16'd1;
          if (bit_q == 16'(CW - 1)) begin
            bit_d   = '0;
            state_d = rnw_q ? ST_TURN : ST_DATA;
          end
        end
      end
      ST_TURN: begin
        if (half) hi_d = ~hi_q;
        if (bit_end) begin
          bit_d = bit_q + 16'd1;
          if (bit_q == 16'(TURN_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (half) hi_d = ~hi_q;
        // Sampled on the last low cycle so the slave has a full half to settle.
        if (sample && rnw_q) rx_d = {rx_q[DBITS-2:0], sdi_i};
        if (bit_end) begin
          sh_d  = {sh_q[SW-2:0], 1'b0};
          bit_d = bit_q + 16'd1;
          if (bit_q == 16'(DBITS - 1)) begin
            bit_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (half) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (rnw_q) rdat_d = rx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      rx_q    <= '0;
      rdat_q  <= '0;
      bit_q   <= '0;
      rnw_q   <= 1'b0;
      hi_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdat_q  <= rdat_d;
      bit_q   <= bit_d;
      rnw_q   <= rnw_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  // Pad control decodes straight from state so csn/sdt can never disagree.
  always_comb begin
    sdt_o = 1'b1;
    sdo_o = 1'b0;
    case (state_q)
      ST_SETUP, ST_CMD: begin
        sdt_o = 1'b0;
        sdo_o = sh_q[SW-1];
      end
      ST_DATA: begin
        sdt_o = rnw_q;
        sdo_o = !rnw_q && sh_q[SW-1];
      end
      ST_HOLD: sdt_o = rnw_q;
      default: sdt_o = 1'b1;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign csn_o  = (state_q == ST_IDLE);
  assign sclk_o = hi_q && ((state_q == ST_CMD) || (state_q == ST_DATA));
  assign done_o = done_q;
  assign rdat_o = rdat_q;

endmodule

// File: tb/tb_sdio_master.sv
// Bench for sdio_master: two instances (CLK_DIV 4 and 2), each with a pad
// model and serial slave; a queue of expected transactions is checked at done_o.
module tb_sdio_master;
  import sdio_master_pkg::*;

  localparam int ABITS = 7;
  localparam int DBITS = 8;

  typedef struct {
    int         inst;
    logic       rnw;
    logic [6:0] addr;
    logic [7:0] wdat;
    logic [7:0] rdat;
    int         acc;
    int         lat;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t exp_q[$];

  logic       rst_s[2], start_s[2], rnw_s[2], busy_s[2], done_s[2];
  logic       sclk_s[2], csn_s[2], sdt_s[2], sdo_s[2], sdi_s[2];
  logic [6:0] addr_s[2];
  logic [7:0] wdat_s[2], rdat_s[2], slave_rdata[2], last_rdat[2];
  int         contention[2], cs_conflict[2], sdt_bad[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_cmd(input logic rnw, input logic [6:0] addr);
    return CMD_RNW_FIRST ? {rnw, addr} : {addr, rnw};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_env
    localparam int CD = (gi == 0) ? 4 : 2;

    sdio_master #(.CLK_DIV(CD), .ABITS(ABITS), .DBITS(DBITS)) u_dut (
      .clk_i  (clk),
      .rst_i  (rst_s[gi]),
      .start_i(start_s[gi]),
      .rnw_i  (rnw_s[gi]),
      .addr_i (addr_s[gi]),
      .wdat_i (wdat_s[gi]),
      .busy_o (busy_s[gi]),
      .done_o (done_s[gi]),
      .rdat_o (rdat_s[gi]),
      .sclk_o (sclk_s[gi]),
      .csn_o  (csn_s[gi]),
      .sdt_o  (sdt_s[gi]),
      .sdo_o  (sdo_s[gi]),
      .sdi_i  (sdi_s[gi])
    );

    int         rises = 0, turn_cnt = 0, last_rise = 0;
    logic       oe = 1'b0, sout = 1'b1, prev_sclk = 1'b0;
    logic [7:0] s_cmd = '0, s_wdat = '0;
    logic [6:0] s_sh = '0;
    txn_t       t;

    // Pad: master drives when T=0; otherwise the slave or a pull-up.
    assign sdi_s[gi] = sdt_s[gi] ? (oe ? sout : 1'b1) : sdo_s[gi];

    always @(negedge clk) begin
      prev_sclk <= sclk_s[gi];
      if (oe && !sdt_s[gi]) contention[gi] <= contention[gi] + 1;
      if (csn_s[gi] && !sdt_s[gi]) cs_conflict[gi] <= cs_conflict[gi] + 1;
      if (csn_s[gi]) begin
        rises    <= 0;
        turn_cnt <= 0;
        oe       <= 1'b0;
      end else begin
        if (sclk_s[gi] && !prev_sclk) begin
          rises     <= rises + 1;
          s_sh      <= {s_sh[5:0], sdo_s[gi]};
          last_rise <= cyc;
          if (rises == 7) s_cmd <= {s_sh, sdo_s[gi]};
          if (rises == 15 && !s_cmd[7]) s_wdat <= {s_sh, sdo_s[gi]};
          if ((rises < 8 || !s_cmd[7]) && sdt_s[gi]) sdt_bad[gi] <= sdt_bad[gi] + 1;
          if (rises >= 1 && rises <= 7) check($sformatf("sclk_period%0d", gi), 32'(cyc - last_rise), 32'(2 * CD));
          if (oe && rises < 15) sout <= slave_rdata[gi][3'(14 - rises)];
        end
        if (rises >= 8 && s_cmd[7] && !oe) begin
          turn_cnt <= turn_cnt + 1;
          if (turn_cnt + 1 >= CD + 1) begin
            oe   <= 1'b1;
            sout <= slave_rdata[gi][7];
          end
        end
      end
    end

    always @(negedge clk) begin
      if (done_s[gi]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("spurious_done%0d", gi), 32'(exp_q.size()), 32'd1);
        end else begin
          t = exp_q.pop_front();
          $display("txn inst=%0d rnw=%0d addr=0x%02h wdat=0x%02h rdat=0x%02h lat=%0d",
                   gi, t.rnw, t.addr, t.wdat, rdat_s[gi], cyc - t.acc);
          check("inst", 32'(gi), 32'(t.inst));
          check("latency", 32'(cyc - t.acc), 32'(t.lat));
          check("slave_cmd", 32'(s_cmd), 32'(exp_cmd(t.rnw, t.addr)));
          if (!t.rnw) check("slave_wdat", 32'(s_wdat), 32'(t.wdat));
          check("rdat", 32'(rdat_s[gi]), 32'(t.rdat));
          check("done_csn", 32'(csn_s[gi]), 32'd1);
          check("done_busy", 32'(busy_s[gi]), 32'd0);
          check("contention", 32'(contention[gi]), 32'd0);
          check("csn_sdt_conflict", 32'(cs_conflict[gi]), 32'd0);
          check("sdt_drive", 32'(sdt_bad[gi]), 32'd0);
        end
      end
    end
  end

  task automatic set_inputs(input int k, input logic rnw, input logic [6:0] addr,
                            input logic [7:0] wdat, input logic [7:0] rd);
    rnw_s[k]       = rnw;
    addr_s[k]      = addr;
    wdat_s[k]      = wdat;
    slave_rdata[k] = rd;
  endtask

  task automatic push_txn(input int k, input logic rnw, input logic [6:0] addr,
                          input logic [7:0] wdat, input logic [7:0] rd);
    txn_t t;
    int   cd;
    cd     = (k == 0) ? 4 : 2;
    t.inst = k;
    t.rnw  = rnw;
    t.addr = addr;
    t.wdat = wdat;
    t.rdat = rnw ? rd : last_rdat[k];
    t.acc  = cyc;
    t.lat  = 2 * cd * (ABITS + 1 + DBITS) + 2 * cd + (rnw ? 2 * cd * TURN_BITS : 0);
    if (rnw) last_rdat[k] = rd;
    exp_q.push_back(t);
  endtask

  task automatic issue(input int k, input logic rnw, input logic [6:0] addr,
                       input logic [7:0] wdat, input logic [7:0] rd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_s[k] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("idle_timeout", 32'(busy_s[k]), 32'd0);
    set_inputs(k, rnw, addr, wdat, rd);
    start_s[k] = 1'b1;
    @(posedge clk);
    #1;
    push_txn(k, rnw, addr, wdat, rd);
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_csn", 32'(csn_s[k]), 32'd1);
    check("rst_sclk", 32'(sclk_s[k]), 32'd0);
    check("rst_sdt", 32'(sdt_s[k]), 32'd1);
    check("rst_sdo", 32'(sdo_s[k]), 32'd0);
    check("rst_busy", 32'(busy_s[k]), 32'd0);
    check("rst_done", 32'(done_s[k]), 32'd0);
    check("rst_rdat", 32'(rdat_s[k]), 32'd0);
  endtask

  initial begin
    int guard;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; start_s[k] = 1'b0; contention[k] = 0; cs_conflict[k] = 0;
      sdt_bad[k] = 0; last_rdat[k] = '0;
      set_inputs(k, 1'b0, 7'h00, 8'h00, 8'h00);
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    // Single write and read at CLK_DIV=4.
    issue(0, 1'b0, 7'h15, 8'hA5, 8'h00);
    drain();
    issue(0, 1'b1, 7'h2C, 8'h00, 8'h3C);
    drain();

    // Back-to-back: next request held high while the write is still busy.
    issue(0, 1'b0, 7'h0F, 8'h69, 8'h00);
    set_inputs(0, 1'b1, 7'h55, 8'hFF, 8'hC3);
    start_s[0] = 1'b1;
    guard = 0;
    while (!done_s[0] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("b2b_timeout", 32'(done_s[0]), 32'd1);
    @(posedge clk);
    #1;
    push_txn(0, 1'b1, 7'h55, 8'hFF, 8'hC3);
    @(negedge clk);
    start_s[0] = 1'b0;
    check("b2b_csn_low", 32'(csn_s[0]), 32'd0);
    drain();

    // start pulsed mid-transaction must be ignored.
    issue(0, 1'b0, 7'h33, 8'h5A, 8'h00);
    repeat (30) @(negedge clk);
    set_inputs(0, 1'b1, 7'h7F, 8'h00, 8'hEE);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("ignored_start_busy", 32'(busy_s[0]), 32'd0);

    // Reset during read DATA: immediate abort, no done, rdat cleared.
    issue(0, 1'b1, 7'h2C, 8'h00, 8'h96);
    repeat (100) @(negedge clk);
    check("pre_rst_busy", 32'(busy_s[0]), 32'd1);
    rst_s[0] = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    rst_s[0] = 1'b0;
    exp_q.delete();
    last_rdat[0] = '0;
    repeat (200) @(negedge clk);
    check("post_rst_busy", 32'(busy_s[0]), 32'd0);
    issue(0, 1'b1, 7'h01, 8'h00, 8'h5A);
    drain();

    // CLK_DIV=2 instance: all-ones, all-zeros and a write.
    issue(1, 1'b1, 7'h7E, 8'h00, 8'hFF);
    drain();
    issue(1, 1'b1, 7'h01, 8'h00, 8'h00);
    drain();
    issue(1, 1'b0, 7'h6A, 8'h81, 8'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
